// File: rtl/cla16_pipe_if.sv
// Operand/result bundle for cla16_pipe: master drives operands and out_ready,
// slave (the adder) drives in_ready and the registered result.
interface cla16_pipe_if;
   // A beat moves on a rising edge where valid && ready; valid never waits on
   // ready, and the sender keeps data stable while valid is high and ready low.
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/cla16_pipe.sv
// Two-stage pipelined 16-bit carry-lookahead adder/subtractor built from gp4
// lookahead units, with valid/ready flow control on both sides.

module gp4 (
   input  logic [3:0] gin,
   input  logic [3:0] pin,
   input  logic       cin,
   output logic       gout,
   output logic       pout,
   output logic [2:0] cout
);
   // cout[j] is the carry into bit j+1 of the group.
   assign cout[0] = gin[0] | (pin[0] & cin);
   assign cout[1] = gin[1] | (pin[1] & gin[0]) | (pin[1] & pin[0] & cin);
   assign cout[2] = gin[2] | (pin[2] & gin[1]) | (pin[2] & pin[1] & gin[0])
                  | (pin[2] & pin[1] & pin[0] & cin);
   assign gout    = gin[3] | (pin[3] & gin[2]) | (pin[3] & pin[2] & gin[1])
                  | (pin[3] & pin[2] & pin[1] & gin[0]);
   assign pout    = &pin;
endmodule

module cla16_pipe #(
   parameter int SUB_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   cla16_pipe_if.slave bus,
   output logic [1:0]  o_dbg_state
);
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   logic        w_sub;
   logic [15:0] w_bx;
   logic        w_cx;
   logic        w_adv2;
   logic        w_xfer;
   logic        w_s1_nxt;
   logic        w_out_nxt;

   logic        r_s1_valid;
   logic        r_out_valid;
   occ_t        r_occ;

   logic [15:0] r_g;
   logic [15:0] r_p;
   logic        r_cx;
   logic        r_a15;
   logic        r_bx15;

   logic [3:0]  w_grp_g;
   logic [3:0]  w_grp_p;
   logic [3:0]  w_grp_cin;
   logic [2:0]  w_lvl2_c;
   logic [1:0]  w_unused_gp;
   logic [2:0]  w_bit_c [4];
   logic [15:0] w_carry;
   logic [15:0] w_sum;
   logic        w_c16;

   logic [15:0] r_sum;
   logic        r_cout;
   logic        r_ovf;
   logic        r_zero;

   // Subtraction is A + ~B + ~cin, so a borrow-in becomes an inverted carry-in.
   assign w_sub = (SUB_EN != 0) && bus.sub;
   assign w_bx  = w_sub ? ~bus.b : bus.b;
   assign w_cx  = w_sub ? ~bus.cin : bus.cin;

   assign w_adv2       = r_s1_valid && (!r_out_valid || bus.out_ready);
   assign bus.in_ready = !r_s1_valid || w_adv2;
   assign w_xfer       = bus.in_valid && bus.in_ready;

   always_comb begin
      w_s1_nxt  = r_s1_valid;
      w_out_nxt = r_out_valid;
      if (w_xfer) begin
         w_s1_nxt = 1'b1;
      end else if (w_adv2) begin
         w_s1_nxt = 1'b0;
      end
      if (w_adv2) begin
         w_out_nxt = 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
         w_out_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_occ       <= OCC_EMPTY;
      end else begin
         r_s1_valid  <= w_s1_nxt;
         r_out_valid <= w_out_nxt;
         case ({w_s1_nxt, w_out_nxt})
            2'b00:   r_occ <= OCC_EMPTY;
            2'b11:   r_occ <= OCC_FULL;
            default: r_occ <= OCC_ONE;
         endcase
      end
   end

   assign o_dbg_state = r_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_g    <= '0;
         r_p    <= '0;
         r_cx   <= 1'b0;
         r_a15  <= 1'b0;
         r_bx15 <= 1'b0;
      end else if (w_xfer) begin
         r_g    <= bus.a & w_bx;
         r_p    <= bus.a ^ w_bx;
         r_cx   <= w_cx;
         r_a15  <= bus.a[15];
         r_bx15 <= w_bx[15];
      end
   end

   // Second level resolves group carry-ins; its own block G/P is not needed
   // because c16 is formed from group 3 and c12.
   assign w_grp_cin = {w_lvl2_c, r_cx};

   gp4 u_lvl2 (
      .gin  (w_grp_g),
      .pin  (w_grp_p),
      .cin  (r_cx),
      .gout (w_unused_gp[1]),
      .pout (w_unused_gp[0]),
      .cout (w_lvl2_c)
   );

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_grp
         gp4 u_gp4 (
            .gin  (r_g[4*k+3:4*k]),
            .pin  (r_p[4*k+3:4*k]),
            .cin  (w_grp_cin[k]),
            .gout (w_grp_g[k]),
            .pout (w_grp_p[k]),
            .cout (w_bit_c[k])
         );
         assign w_carry[4*k]           = w_grp_cin[k];
         assign w_carry[4*k+3:4*k+1]   = w_bit_c[k];
      end
   endgenerate

   assign w_c16 = w_grp_g[3] | (w_grp_p[3] & w_lvl2_c[2]);
   assign w_sum = r_p ^ w_carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_adv2) begin
         r_sum  <= w_sum;
         r_cout <= w_c16;
         r_ovf  <= (r_a15 == r_bx15) && (w_sum[15] != r_a15);
         r_zero <= (w_sum == 16'h0000);
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
   assign bus.zero      = r_zero;
endmodule
